// File: rtl/seg7_marquee_controller.sv
// rtl/seg7_marquee_controller.sv - N-digit multiplexed 7-segment driver with message buffer, marquee and blink
module seg7_marquee_controller #(
    parameter int NUM_DIGITS     = 8,
    parameter int BUF_DEPTH      = 32,
    parameter int SCROLL_DIV     = 125,
    parameter int BLINK_DIV      = 250,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                               clk_500hz,
    input  logic                               rst,
    input  logic [7:0]                         char_in,
    input  logic                               char_valid,
    input  logic                               backspace,
    input  logic                               clear,
    input  logic                               scroll_en,
    input  logic                               blink_en,
    output logic [7:0]                         seg,
    output logic [NUM_DIGITS-1:0]              digit_sel,
    output logic [$clog2(BUF_DEPTH+1)-1:0]     char_count,
    output logic                               buf_full
);

    localparam int CW  = $clog2(BUF_DEPTH + 1);
    localparam int PW  = CW + 1;
    localparam int AW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int SW  = $clog2(NUM_DIGITS);
    localparam int SCW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [7:0]            SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    logic [7:0]      msg [BUF_DEPTH];
    logic [PW-1:0]   offset;
    logic [SW-1:0]   scan_idx;
    logic [SCW-1:0]  scroll_cnt;
    logic [BCW-1:0]  blink_cnt;
    logic            blink_on;

    logic [PW-1:0]   cnt_ext, len, step_len, pos_sum, pos;
    logic            marquee, bs_ok, wr_ok, scroll_wrap, show;
    logic [7:0]      ch, glyph;
    logic [NUM_DIGITS-1:0] onehot;

    function automatic logic [7:0] font(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= "a" && c <= "z") ? c - 8'd32 : c;
        case (u)
            "A": font = 8'h77;  "B": font = 8'h7C;  "C": font = 8'h39;  "D": font = 8'h5E;
            "E": font = 8'h79;  "F": font = 8'h71;  "G": font = 8'h3D;  "H": font = 8'h76;
            "I": font = 8'h06;  "J": font = 8'h1E;  "K": font = 8'h75;  "L": font = 8'h38;
            "M": font = 8'h15;  "N": font = 8'h54;  "O": font = 8'h3F;  "P": font = 8'h73;
            "Q": font = 8'h67;  "R": font = 8'h50;  "S": font = 8'h6D;  "T": font = 8'h78;
            "U": font = 8'h3E;  "V": font = 8'h1C;  "W": font = 8'h2A;  "X": font = 8'h76;
            "Y": font = 8'h6E;  "Z": font = 8'h5B;
            "0": font = 8'h3F;  "1": font = 8'h06;  "2": font = 8'h5B;  "3": font = 8'h4F;
            "4": font = 8'h66;  "5": font = 8'h6D;  "6": font = 8'h7D;  "7": font = 8'h07;
            "8": font = 8'h7F;  "9": font = 8'h6F;
            "-": font = 8'h40;  ".": font = 8'h80;
            default: font = 8'h00;
        endcase
    endfunction

    always_comb begin
        cnt_ext     = {1'b0, char_count};
        len         = cnt_ext + 1'b1;
        buf_full    = (char_count == CW'(BUF_DEPTH));
        marquee     = scroll_en && (char_count > CW'(NUM_DIGITS));
        bs_ok       = !clear && backspace && (char_count != '0);
        wr_ok       = !clear && !backspace && char_valid && !buf_full;
        // A backspace shrinks the ring this cycle, so offset stepping must respect the new length
        step_len    = bs_ok ? cnt_ext : len;
        scroll_wrap = (scroll_cnt == SCW'(SCROLL_DIV - 1));
        // offset < L and scan_idx < C < L, so one conditional subtraction yields the modulo
        pos_sum     = offset + PW'(scan_idx);
        pos         = marquee ? ((pos_sum >= len) ? pos_sum - len : pos_sum) : PW'(scan_idx);
        show        = (pos < cnt_ext);
        ch          = show ? msg[pos[AW-1:0]] : 8'h20;
        glyph       = font(ch);
        onehot      = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << scan_idx;
    end

    always_ff @(posedge clk_500hz) begin
        if (wr_ok)
            msg[char_count[AW-1:0]] <= char_in;
    end

    always_ff @(posedge clk_500hz or posedge rst) begin
        if (rst) begin
            char_count <= '0;
            offset     <= '0;
            scroll_cnt <= '0;
            scan_idx   <= '0;
            blink_cnt  <= '0;
            blink_on   <= 1'b1;
            seg        <= SEG_OFF;
            digit_sel  <= DIG_OFF;
        end else begin
            scan_idx <= (scan_idx == SW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;

            if (clear)
                char_count <= '0;
            else if (bs_ok)
                char_count <= char_count - 1'b1;
            else if (wr_ok)
                char_count <= char_count + 1'b1;

            if (clear || !marquee) begin
                offset     <= '0;
                scroll_cnt <= '0;
            end else begin
                scroll_cnt <= scroll_wrap ? '0 : scroll_cnt + 1'b1;
                if (bs_ok && offset >= step_len)
                    offset <= '0;
                else if (scroll_wrap)
                    offset <= (offset + 1'b1 >= step_len) ? '0 : offset + 1'b1;
            end

            if (!blink_en) begin
                blink_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (blink_cnt == BCW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_on  <= !blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            seg       <= blink_on ? (glyph ^ SEG_OFF) : SEG_OFF;
            digit_sel <= blink_on ? (onehot ^ DIG_OFF) : DIG_OFF;
        end
    end

endmodule

// File: tb/tb_seg7_marquee_controller.sv
// tb/tb_seg7_marquee_controller.sv - directed self-checking bench for seg7_marquee_controller
module tb_seg7_marquee_controller;

    logic       clk_500hz = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] char_in = 8'h00;
    logic       char_valid = 1'b0;
    logic       backspace = 1'b0;
    logic       clear = 1'b0;
    logic       scroll_en = 1'b0;
    logic       blink_en = 1'b0;

    logic [7:0] seg_a, seg_b;
    logic [7:0] dig_a, dig_b;
    logic [5:0] cc_a, cc_b;
    logic       full_a, full_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0] abc_glyph [10] = '{8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71, 8'h3D, 8'h76, 8'h06, 8'h1E};
    logic [7:0] frame_exp [8];

    seg7_marquee_controller #(
        .NUM_DIGITS(8), .BUF_DEPTH(32), .SCROLL_DIV(2), .BLINK_DIV(4),
        .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
    ) dut_a (
        .clk_500hz(clk_500hz), .rst(rst), .char_in(char_in), .char_valid(char_valid),
        .backspace(backspace), .clear(clear), .scroll_en(scroll_en), .blink_en(blink_en),
        .seg(seg_a), .digit_sel(dig_a), .char_count(cc_a), .buf_full(full_a)
    );

    seg7_marquee_controller #(
        .NUM_DIGITS(8), .BUF_DEPTH(32), .SCROLL_DIV(2), .BLINK_DIV(4),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut_b (
        .clk_500hz(clk_500hz), .rst(rst), .char_in(char_in), .char_valid(char_valid),
        .backspace(backspace), .clear(clear), .scroll_en(scroll_en), .blink_en(blink_en),
        .seg(seg_b), .digit_sel(dig_b), .char_count(cc_b), .buf_full(full_b)
    );

    always #5 clk_500hz = ~clk_500hz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_500hz);
        #1;
        cyc++;
    endtask

    task automatic write_char(input logic [7:0] c);
        char_in = c;
        char_valid = 1'b1;
        tick();
        char_valid = 1'b0;
    endtask

    task automatic check_frame(input string tag);
        for (int k = 0; k < 8; k++) begin
            int d;
            tick();
            d = (cyc - 1) % 8;
            check({tag, "_sel"}, 32'(dig_a), 32'(1 << d));
            check({tag, "_seg"}, 32'(seg_a), 32'(frame_exp[d]));
        end
    endtask

    initial begin
        // Reset state while rst is held
        repeat (2) @(posedge clk_500hz);
        #1;
        check("rst_seg_a", 32'(seg_a), 32'h00);
        check("rst_sel_a", 32'(dig_a), 32'h00);
        check("rst_seg_b", 32'(seg_b), 32'hFF);
        check("rst_sel_b", 32'(dig_b), 32'hFF);
        check("rst_count", 32'(cc_a), 32'd0);
        check("rst_full", 32'(full_a), 32'd0);
        rst = 1'b0;
        cyc = 0;

        // Idle scan: one-hot walk, all blank, including the 80 -> 01 wrap
        for (int k = 0; k < 9; k++) begin
            tick();
            check("idle_sel", 32'(dig_a), 32'(1 << ((cyc - 1) % 8)));
            check("idle_seg", 32'(seg_a), 32'h00);
        end

        // Static "HI12"
        write_char("H");
        write_char("i");
        write_char("1");
        write_char("2");
        tick();
        check("hi12_count", 32'(cc_a), 32'd4);
        frame_exp = '{8'h76, 8'h06, 8'h06, 8'h5B, 8'h00, 8'h00, 8'h00, 8'h00};
        check_frame("hi12");

        // Fill to BUF_DEPTH, overflow drop, backspace beats char_valid
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_count", 32'(cc_a), 32'd0);
        for (int k = 0; k < 31; k++)
            write_char(8'h41 + 8'(k % 10));
        check("full_at31", 32'(full_a), 32'd0);
        write_char(8'h41 + 8'(31 % 10));
        check("full_at32", 32'(full_a), 32'd1);
        check("count_32", 32'(cc_a), 32'd32);
        write_char("9");
        check("count_drop", 32'(cc_a), 32'd32);
        for (int k = 0; k < 8; k++)
            frame_exp[k] = abc_glyph[k];
        check_frame("full");
        backspace = 1'b1;
        char_valid = 1'b1;
        char_in = "Z";
        tick();
        backspace = 1'b0;
        char_valid = 1'b0;
        check("bs_vs_wr", 32'(cc_a), 32'd31);
        check("bs_full", 32'(full_a), 32'd0);

        // clear wins over char_valid
        clear = 1'b1;
        char_valid = 1'b1;
        char_in = "Q";
        tick();
        clear = 1'b0;
        char_valid = 1'b0;
        check("clr_vs_wr", 32'(cc_a), 32'd0);

        // Marquee on "ABCDEFGHIJ": L=11, step every 2 cycles
        for (int k = 0; k < 10; k++)
            write_char(8'h41 + 8'(k));
        tick();
        scroll_en = 1'b1;
        for (int i = 1; i <= 43; i++) begin
            int d, off, p;
            if (i == 43) backspace = 1'b1;
            tick();
            backspace = 1'b0;
            d = (cyc - 1) % 8;
            off = ((i - 1) / 2) % 11;
            p = (off + d) % 11;
            check("mq_sel", 32'(dig_a), 32'(1 << d));
            check("mq_seg", 32'(seg_a), (p < 10) ? 32'(abc_glyph[p]) : 32'h00);
        end
        check("mq_bs_count", 32'(cc_a), 32'd9);
        // After backspace at offset 10 the ring is L=10 and offset restarts at 0
        for (int i = 44; i <= 51; i++) begin
            int d, off, p;
            tick();
            d = (cyc - 1) % 8;
            off = (i - 43) / 2;
            p = (off + d) % 10;
            check("mq9_seg", 32'(seg_a), (p < 9) ? 32'(abc_glyph[p]) : 32'h00);
        end

        // Asynchronous reset mid-marquee
        #2;
        rst = 1'b1;
        #1;
        check("arst_seg_a", 32'(seg_a), 32'h00);
        check("arst_sel_a", 32'(dig_a), 32'h00);
        check("arst_seg_b", 32'(seg_b), 32'hFF);
        check("arst_sel_b", 32'(dig_b), 32'hFF);
        check("arst_count", 32'(cc_b), 32'd0);
        @(posedge clk_500hz);
        #1;
        rst = 1'b0;
        scroll_en = 1'b0;
        cyc = 0;
        frame_exp = '{default: 8'h00};
        check_frame("post_rst");

        // Blink with "8": 4 cycles on, 4 off, both polarities
        write_char("8");
        tick();
        blink_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            int d;
            logic on;
            logic [7:0] g;
            tick();
            d = (cyc - 1) % 8;
            on = (((i - 1) / 4) % 2) == 0;
            g = (d == 0) ? 8'h7F : 8'h00;
            check("blk_sel_a", 32'(dig_a), on ? 32'(1 << d) : 32'h00);
            check("blk_seg_a", 32'(seg_a), on ? 32'(g) : 32'h00);
            check("blk_sel_b", 32'(dig_b), on ? 32'(8'hFF ^ 8'(1 << d)) : 32'hFF);
            check("blk_seg_b", 32'(seg_b), on ? 32'(8'hFF ^ g) : 32'hFF);
        end
        check("blk_full_b", 32'(full_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg7_marquee_controller.md
Name: seg7_marquee_controller

Overview:
Parametrised N-digit multiplexed 7-segment driver with a message buffer deeper than the display.
- Accepts ASCII characters one per cycle and supports backspace and clear.
- Shows the message statically when it fits, or as a wrapping marquee when it is longer than the display.
- Provides optional whole-display blink and configurable segment/digit polarity.
- Sits between the character source (keypad/UART decoder) and the board display pins, clocked by the 500 Hz scan tick.

Parameters:
- NUM_DIGITS, 8: physical digits, 2..16.
- BUF_DEPTH, 32: message buffer entries, NUM_DIGITS..64.
- SCROLL_DIV, 125: scan ticks per marquee step (250 ms at 500 Hz), >=1.
- BLINK_DIV, 250: scan ticks per blink half-period, >=1.
- SEG_ACTIVE_LOW, 0: 1 inverts seg outputs (common anode).
- DIG_ACTIVE_LOW, 0: 1 inverts digit_sel outputs.

Ports:
- clk_500hz, input, 1: scan/system clock.
- rst, input, 1: reset, asynchronous, active-high.
- char_in, input, 8: ASCII character to append.
- char_valid, input, 1: append char_in this cycle.
- backspace, input, 1: remove the last character.
- clear, input, 1: synchronous buffer clear.
- scroll_en, input, 1: enable marquee when the message is longer than the display.
- blink_en, input, 1: enable blink.
- seg, output, 8: segments {dp,g,f,e,d,c,b,a}, registered.
- digit_sel, output, NUM_DIGITS: one-hot digit enable, registered; bit0 = leftmost digit = first character.
- char_count, output, clog2(BUF_DEPTH+1): number of stored characters.
- buf_full, output, 1: char_count == BUF_DEPTH.

Behaviour:
- Reset (async):
  - Buffer contents are don't-care; char_count=0; scroll offset=0.
  - scan_idx=0; scroll/blink counters=0; blink phase=on.
  - seg = all-inactive (8'h00, or 8'hFF if SEG_ACTIVE_LOW); digit_sel = all-inactive.
- Scan:
  - scan_idx increments each cycle and wraps NUM_DIGITS-1 -> 0.
  - digit_sel/seg are registered from the current scan_idx, so outputs for digit d appear one cycle after scan_idx==d.
  - Exactly one digit is active per cycle, or none while blanked by blink.
- Buffer command priority: rst > clear > backspace > char_valid.
  - clear: char_count<=0, offset<=0, scroll counter<=0.
  - backspace: if char_count>0, decrement; else no-op. A simultaneous char_valid is dropped.
  - char_valid: if !buf_full, buf[char_count]<=char_in and char_count++. If buf_full, the write is dropped silently and the buffer is unchanged (no wrap, no overwrite).
- Display mapping:
  - Let C = char_count and L = C+1 (one trailing blank gap).
  - Static mode (scroll_en=0 or C<=NUM_DIGITS):
    - Offset is held at 0.
    - Digit d shows buf[d] if d<C, else blank.
  - Marquee mode (scroll_en=1 and C>NUM_DIGITS):
    - Digit d shows position p=(offset+d) mod L; p==C shows blank.
    - Scroll counter counts to SCROLL_DIV-1; on wrap, offset <= (offset+1==L) ? 0 : offset+1.
  - Leaving marquee mode (scroll_en falls or C drops to <=NUM_DIGITS): offset<=0 and scroll counter<=0 the next cycle.
  - If a backspace makes offset >= new L: offset<=0.
  - The modulo is implemented by conditional subtraction; no divider.
- Font:
  - A-Z/a-z case-insensitive, 0-9, '-'=g only, '.'=dp only, space and all other codes = blank.
  - Letter glyphs: A 77, b 7C, C 39, d 5E, E 79, F 71, G 3D, H 76, I 06, J 1E, K 75, L 38, M 15, n 54, O 3F, P 73, q 67, r 50, S 6D, t 78, U 3E, V 1C, W 2A, X 76, Y 6E, Z 5B.
  - Digit glyphs: 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F.
  - All glyph values are active-high hex before polarity inversion.
- Blink:
  - When blink_en=1, the blink counter wraps at BLINK_DIV-1 and toggles the phase.
  - Phase off: seg and digit_sel are driven all-inactive.
  - blink_en=0: phase forced on and counter held at 0.
- Reset asserted mid-marquee or mid-blink: outputs go inactive immediately; all state returns to reset values.

Test Plan:
- Reset release, no input, NUM_DIGITS=8 -> digit_sel cycles 01,02,..,80,01 one cycle after scan_idx; seg=00 on every digit; char_count=0.
- Write "HI" then "12", scroll_en=0 -> digit0 seg=76, digit1 06, digit2 06, digit3 5B, digits4-7 00; char_count=4.
- Write 33 chars into BUF_DEPTH=32 -> buf_full=1 after the 32nd, 33rd dropped, char_count=32. Then backspace+char_valid in the same cycle -> char_count=31, char dropped.
- Write "ABCDEFGHIJ" (C=10), scroll_en=1, SCROLL_DIV=2:
  - Offset steps every 2 cycles. At offset=3, digit0..7 show D,E,F,G,H,I,J,blank.
  - Offset 10 -> 0 wrap.
  - Backspace at offset 10 -> offset=0.
- blink_en=1, BLINK_DIV=4, "8" stored -> digit0 seg=7F for 4 cycles, then all-inactive for 4 cycles, repeating. With SEG_ACTIVE_LOW=1 and DIG_ACTIVE_LOW=1, "8" -> seg=80 and digit_sel=FE on digit0.
- rst pulse mid-marquee (offset=5) -> seg/digit_sel inactive that same cycle, char_count=0, offset=0. clear during char_valid -> char_count=0, char not stored.
